// File: rtl/pipelined_riscv_uc.sv
// Control unit and hazard unit for a five-stage RV32I subset pipeline.
// Decodes in D, carries controls through E/M/W banks, and resolves load-use stalls, flushes and forwarding.

package pipelined_riscv_uc_pkg;

  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNC3_W   = 3;
  localparam int unsigned FUNC7_W   = 7;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ALU_CTL_W = 3;
  localparam int unsigned RES_SRC_W = 2;
  localparam int unsigned IMM_SRC_W = 2;
  localparam int unsigned FWD_W     = 2;

  typedef struct packed {
    logic                 reg_write;
    logic [RES_SRC_W-1:0] result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic [ALU_CTL_W-1:0] alu_control;
    logic                 alu_src;
  } ctrl_e_t;

  typedef struct packed {
    logic                 reg_write;
    logic [RES_SRC_W-1:0] result_src;
    logic                 mem_write;
  } ctrl_m_t;

  typedef struct packed {
    logic                 reg_write;
    logic [RES_SRC_W-1:0] result_src;
  } ctrl_w_t;

endpackage

module pipelined_riscv_uc
  import pipelined_riscv_uc_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNC3_W-1:0]   func3,
  input  logic [FUNC7_W-1:0]   func7,
  input  logic                 zeroE,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] Rs1E,
  input  logic [REG_IDX_W-1:0] Rs2E,
  input  logic [REG_IDX_W-1:0] RdE,
  input  logic [REG_IDX_W-1:0] RdM,
  input  logic [REG_IDX_W-1:0] RdW,
  output logic [IMM_SRC_W-1:0] ImmSrcD,
  output logic                 ALUSrcE,
  output logic [ALU_CTL_W-1:0] ALUControlE,
  output logic                 PCSrcE,
  output logic                 MemWriteM,
  output logic [RES_SRC_W-1:0] ResultSrcW,
  output logic                 RegWriteW,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [FWD_W-1:0]     ForwardAE,
  output logic [FWD_W-1:0]     ForwardBE
);

  localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IALU  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;

  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = 3'b101;

  localparam logic [RES_SRC_W-1:0] RES_ALU = 2'b00;
  localparam logic [RES_SRC_W-1:0] RES_MEM = 2'b01;
  localparam logic [RES_SRC_W-1:0] RES_PC4 = 2'b10;

  ctrl_e_t               dec_d;
  ctrl_e_t               ctrl_e;
  ctrl_m_t               ctrl_m;
  ctrl_w_t               ctrl_w;
  logic [IMM_SRC_W-1:0]  imm_src_d;
  logic [ALU_CTL_W-1:0]  arith_op;
  logic                  lw_stall;
  logic                  pc_src_e;
  logic                  unused_func7;

  // Only func7[5] selects between add and sub.
  assign unused_func7 = ^{func7[6], func7[4:0]};

  // Arithmetic/logic operation for R-type and I-ALU; only R-type can turn add into sub.
  always_comb begin
    arith_op = ALU_ADD;
    case (func3)
      3'b000:  arith_op = ((opcode == OP_RTYPE) && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  arith_op = ALU_SLT;
      3'b110:  arith_op = ALU_OR;
      3'b111:  arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  // Main decoder; unknown opcodes fall through to an all-zero bubble.
  always_comb begin
    dec_d     = '0;
    imm_src_d = 2'b00;
    case (opcode)
      OP_LOAD: begin
        dec_d.reg_write  = 1'b1;
        dec_d.result_src = RES_MEM;
        dec_d.alu_src    = 1'b1;
        imm_src_d        = 2'b00;
      end
      OP_STORE: begin
        dec_d.mem_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        imm_src_d       = 2'b01;
      end
      OP_RTYPE: begin
        dec_d.reg_write   = 1'b1;
        dec_d.result_src  = RES_ALU;
        dec_d.alu_control = arith_op;
      end
      OP_IALU: begin
        dec_d.reg_write   = 1'b1;
        dec_d.result_src  = RES_ALU;
        dec_d.alu_src     = 1'b1;
        dec_d.alu_control = arith_op;
        imm_src_d         = 2'b00;
      end
      OP_BEQ: begin
        dec_d.branch      = 1'b1;
        dec_d.alu_control = ALU_SUB;
        imm_src_d         = 2'b10;
      end
      OP_JAL: begin
        dec_d.reg_write  = 1'b1;
        dec_d.result_src = RES_PC4;
        dec_d.jump       = 1'b1;
        imm_src_d        = 2'b11;
      end
      default: begin
        dec_d     = '0;
        imm_src_d = 2'b00;
      end
    endcase
  end

  // Pipeline control banks; only D->E can be flushed, none stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_e <= '0;
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      ctrl_e <= FlushE ? ctrl_e_t'('0) : dec_d;
      ctrl_m <= '{reg_write:  ctrl_e.reg_write,
                  result_src: ctrl_e.result_src,
                  mem_write:  ctrl_e.mem_write};
      ctrl_w <= '{reg_write:  ctrl_m.reg_write,
                  result_src: ctrl_m.result_src};
    end
  end

  assign pc_src_e = ctrl_e.jump | (ctrl_e.branch & zeroE);

  // Load-use hazard: a load in E whose destination feeds the instruction in D.
  assign lw_stall = (ctrl_e.result_src == RES_MEM) && (RdE != '0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

  // Memory-stage result is newer than Writeback, so it wins; x0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if ((Rs1E != '0) && ctrl_m.reg_write && (RdM == Rs1E)) begin
      ForwardAE = 2'b10;
    end else if ((Rs1E != '0) && ctrl_w.reg_write && (RdW == Rs1E)) begin
      ForwardAE = 2'b01;
    end
    if ((Rs2E != '0) && ctrl_m.reg_write && (RdM == Rs2E)) begin
      ForwardBE = 2'b10;
    end else if ((Rs2E != '0) && ctrl_w.reg_write && (RdW == Rs2E)) begin
      ForwardBE = 2'b01;
    end
  end

  assign ImmSrcD     = imm_src_d;
  assign ALUSrcE     = ctrl_e.alu_src;
  assign ALUControlE = ctrl_e.alu_control;
  assign PCSrcE      = pc_src_e;
  assign MemWriteM   = ctrl_m.mem_write;
  assign ResultSrcW  = ctrl_w.result_src;
  assign RegWriteW   = ctrl_w.reg_write;
  assign StallF      = lw_stall;
  assign StallD      = lw_stall;
  assign FlushD      = pc_src_e;
  assign FlushE      = lw_stall | pc_src_e;

endmodule

// File: tb/tb_pipelined_riscv_uc.sv
// Bench for pipelined_riscv_uc: directed instruction sequences plus randomized traffic,
// all checked every cycle against a stage-by-stage reference of what each instruction should produce.

module tb_pipelined_riscv_uc;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zeroE;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ImmSrcD;
  logic       ALUSrcE;
  logic [2:0] ALUControlE;
  logic       PCSrcE;
  logic       MemWriteM;
  logic [1:0] ResultSrcW;
  logic       RegWriteW;
  logic       StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;

  int vectors = 0;
  int miscompares = 0;

  localparam bit [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam bit [6:0] IA = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  pipelined_riscv_uc dut (
    .clock(clock), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .zeroE(zeroE), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .PCSrcE(PCSrcE), .MemWriteM(MemWriteM),
    .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  always #5 clock = ~clock;

  // What an instruction means, independent of where it sits in the pipe.
  typedef struct packed {
    bit       rw;
    bit [1:0] rs;
    bit       mw;
    bit       jmp;
    bit       br;
    bit [2:0] alu;
    bit       asrc;
    bit [1:0] imm;
  } ctl_t;

  ctl_t e_q, m_q, w_q;

  function automatic ctl_t decode(bit [6:0] op, bit [2:0] f3, bit [6:0] f7);
    ctl_t c;
    bit [2:0] arith;
    c = '0;
    if (f3 == 3'b010)      arith = 3'b101;
    else if (f3 == 3'b110) arith = 3'b011;
    else if (f3 == 3'b111) arith = 3'b010;
    else if (f3 == 3'b000 && op == RT && f7[5]) arith = 3'b001;
    else                   arith = 3'b000;
    if (op == LW)      begin c.rw = 1; c.rs = 2'b01; c.asrc = 1; c.imm = 2'b00; end
    else if (op == SW) begin c.mw = 1; c.asrc = 1; c.imm = 2'b01; end
    else if (op == RT) begin c.rw = 1; c.alu = arith; end
    else if (op == IA) begin c.rw = 1; c.asrc = 1; c.alu = arith; end
    else if (op == BQ) begin c.br = 1; c.alu = 3'b001; c.imm = 2'b10; end
    else if (op == JL) begin c.rw = 1; c.jmp = 1; c.rs = 2'b10; c.imm = 2'b11; end
    return c;
  endfunction

  function automatic bit [1:0] fwd(bit [4:0] rs);
    if (rs != 0 && m_q.rw && RdM == rs) return 2'b10;
    if (rs != 0 && w_q.rw && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_stall();
    return (e_q.rs == 2'b01) && (RdE != 0) && (Rs1D == RdE || Rs2D == RdE);
  endfunction

  function automatic bit exp_pcsrc();
    return e_q.jmp || (e_q.br && zeroE);
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    ctl_t d;
    d = decode(opcode, func3, func7);
    check("ImmSrcD", 8'(ImmSrcD), 8'(d.imm));
    check("ALUSrcE", 8'(ALUSrcE), 8'(e_q.asrc));
    check("ALUControlE", 8'(ALUControlE), 8'(e_q.alu));
    check("PCSrcE", 8'(PCSrcE), 8'(exp_pcsrc()));
    check("MemWriteM", 8'(MemWriteM), 8'(m_q.mw));
    check("ResultSrcW", 8'(ResultSrcW), 8'(w_q.rs));
    check("RegWriteW", 8'(RegWriteW), 8'(w_q.rw));
    check("StallF", 8'(StallF), 8'(exp_stall()));
    check("StallD", 8'(StallD), 8'(exp_stall()));
    check("FlushD", 8'(FlushD), 8'(exp_pcsrc()));
    check("FlushE", 8'(FlushE), 8'(exp_stall() || exp_pcsrc()));
    check("ForwardAE", 8'(ForwardAE), 8'(fwd(Rs1E)));
    check("ForwardBE", 8'(ForwardBE), 8'(fwd(Rs2E)));
  endtask

  task automatic dflt();
    opcode = 7'h00; func3 = 3'b000; func7 = 7'h00; zeroE = 1'b0;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
  endtask

  // Inputs are already applied; compare mid-cycle.
  task automatic settle();
    if (!reset) begin e_q = '0; m_q = '0; w_q = '0; end
    @(negedge clock);
    compare_all();
  endtask

  // Advance the reference by one clock using the inputs seen at the edge.
  task automatic tick();
    bit flush;
    @(posedge clock);
    flush = exp_stall() || exp_pcsrc();
    if (!reset) begin
      e_q = '0; m_q = '0; w_q = '0;
    end else begin
      w_q = m_q;
      m_q = e_q;
      e_q = flush ? ctl_t'('0) : decode(opcode, func3, func7);
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    dflt();
    e_q = '0; m_q = '0; w_q = '0;
    #2;
    check("rst_RegWriteW", 8'(RegWriteW), 8'h0);
    check("rst_FlushE", 8'(FlushE), 8'h0);
    check("rst_ForwardAE", 8'(ForwardAE), 8'h0);
    settle();
    tick();
    reset = 1'b1;

    // add x3,x1,x2 ; sub x4,x3,x5
    dflt(); opcode = RT; settle(); tick();
    dflt(); opcode = RT; func7 = 7'h20; settle(); tick();
    dflt(); Rs1E = 3; Rs2E = 5; RdM = 3; settle();
    check("fwd_sub_A", 8'(ForwardAE), 8'h2);
    check("fwd_sub_B", 8'(ForwardBE), 8'h0);
    check("sub_aluctl", 8'(ALUControlE), 8'h1);
    tick();

    // lw x6,0(x1) ; add x7,x6,x2
    dflt(); opcode = LW; settle(); tick();
    dflt(); opcode = RT; Rs1D = 6; Rs2D = 2; RdE = 6; settle();
    check("lu_StallF", 8'(StallF), 8'h1);
    check("lu_StallD", 8'(StallD), 8'h1);
    check("lu_FlushE", 8'(FlushE), 8'h1);
    tick();
    dflt(); opcode = RT; Rs1D = 6; Rs2D = 2; RdM = 6; settle();
    check("lu_release", 8'(StallF), 8'h0);
    tick();
    dflt(); Rs1E = 6; Rs2E = 2; RdW = 6; settle();
    check("lu_fwdW", 8'(ForwardAE), 8'h1);
    check("lu_ResultSrcW", 8'(ResultSrcW), 8'h1);
    tick();

    // beq taken, then not taken
    dflt(); opcode = BQ; settle();
    check("beq_imm", 8'(ImmSrcD), 8'h2);
    tick();
    dflt(); opcode = RT; func3 = 3'b111; zeroE = 1; settle();
    check("beq_PCSrcE", 8'(PCSrcE), 8'h1);
    check("beq_FlushD", 8'(FlushD), 8'h1);
    check("beq_FlushE", 8'(FlushE), 8'h1);
    tick();
    dflt(); settle();
    check("beq_bubble_alu", 8'(ALUControlE), 8'h0);
    check("beq_bubble_pc", 8'(PCSrcE), 8'h0);
    tick();
    dflt(); opcode = BQ; settle(); tick();
    dflt(); settle();
    check("beq_nt_PCSrcE", 8'(PCSrcE), 8'h0);
    check("beq_nt_FlushE", 8'(FlushE), 8'h0);
    tick();

    // jal x1
    dflt(); opcode = JL; settle();
    check("jal_imm", 8'(ImmSrcD), 8'h3);
    tick();
    dflt(); settle(); check("jal_PCSrcE", 8'(PCSrcE), 8'h1); tick();
    dflt(); settle(); tick();
    dflt(); settle();
    check("jal_ResultSrcW", 8'(ResultSrcW), 8'h2);
    check("jal_RegWriteW", 8'(RegWriteW), 8'h1);
    tick();

    // sw x5,4(x2) ; illegal opcode
    dflt(); opcode = SW; settle(); check("sw_imm", 8'(ImmSrcD), 8'h1); tick();
    dflt(); settle(); check("sw_ALUSrcE", 8'(ALUSrcE), 8'h1); tick();
    dflt(); settle(); check("sw_MemWriteM", 8'(MemWriteM), 8'h1); tick();
    dflt(); settle();
    check("sw_MemWriteM_once", 8'(MemWriteM), 8'h0);
    check("sw_RegWriteW", 8'(RegWriteW), 8'h0);
    tick();
    dflt(); opcode = 7'h7f; func3 = 3'b111; func7 = 7'h7f; settle();
    check("ill_imm", 8'(ImmSrcD), 8'h0);
    tick();
    dflt(); settle(); check("ill_ALUSrcE", 8'(ALUSrcE), 8'h0); tick();

    // Asynchronous reset with a store in M and a load in W
    dflt(); opcode = LW; settle(); tick();
    dflt(); opcode = SW; settle(); tick();
    dflt(); settle(); tick();
    dflt(); settle();
    check("pre_rst_MemWriteM", 8'(MemWriteM), 8'h1);
    check("pre_rst_RegWriteW", 8'(RegWriteW), 8'h1);
    #1 reset = 1'b0;
    #1;
    check("async_MemWriteM", 8'(MemWriteM), 8'h0);
    check("async_RegWriteW", 8'(RegWriteW), 8'h0);
    e_q = '0; m_q = '0; w_q = '0;
    tick();
    reset = 1'b1;

    // Randomized traffic, with occasional mid-stream resets
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: opcode = LW;
        1: opcode = SW;
        2: opcode = RT;
        3: opcode = IA;
        4: opcode = BQ;
        5: opcode = JL;
        6: opcode = RT;
        default: opcode = 7'($urandom);
      endcase
      func3 = 3'($urandom);
      func7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom);
      zeroE = 1'($urandom);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      reset = ($urandom_range(0, 63) != 0);
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
